// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S / left-justified stream receiver.
package i2s_pkg;

    localparam int I2S_MODE_I2S = 0;
    localparam int I2S_MODE_LJ  = 1;

    localparam logic I2S_CHAN_LEFT  = 1'b0;
    localparam logic I2S_CHAN_RIGHT = 1'b1;

    // Wide enough to count up to the largest allowed slot (64 bits).
    localparam int I2S_CNT_W = 7;

    typedef enum logic {
        I2S_ST_IDLE  = 1'b0,
        I2S_ST_SHIFT = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-stage synchroniser for the three I2S pins plus a one-clk strobe on each
// rising edge of the synchronised bit clock.
module i2s_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic lrck_i,
    input  logic sdin_i,
    output logic lrck_o,
    output logic sdin_o,
    output logic rise_o
);

    // All three pins travel through the same chain so they stay mutually aligned.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        sclk_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], {sclk_i, lrck_i, sdin_i}};
            sclk_prev_q <= sync_q[SYNC_STAGES-1][2];
        end
    end

    assign lrck_o = sync_q[SYNC_STAGES-1][1];
    assign sdin_o = sync_q[SYNC_STAGES-1][0];
    assign rise_o = sync_q[SYNC_STAGES-1][2] & ~sclk_prev_q;

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S / left-justified audio receiver: oversampled pins, MSB-first slot
// deserialiser and a single-entry valid/ready output register.
module i2s_rx_stream
    import i2s_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int SLOT_MAX    = 32,
    parameter int MODE        = I2S_MODE_I2S,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclk,
    input  logic             lrck,
    input  logic             sdin,
    output logic [WIDTH-1:0] m_data,
    output logic             m_chan,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    output logic             short_slot
);

    localparam logic [I2S_CNT_W-1:0] WIDTH_C    = I2S_CNT_W'(WIDTH);
    localparam logic [I2S_CNT_W-1:0] WIDTH_M1_C = I2S_CNT_W'(WIDTH - 1);
    localparam logic [I2S_CNT_W-1:0] SLOT_MAX_C = I2S_CNT_W'(SLOT_MAX);
    localparam logic [I2S_CNT_W-1:0] ONE_C      = I2S_CNT_W'(1);
    localparam bit                   LJ         = (MODE == I2S_MODE_LJ);

    logic rise, lrck_s, sdin_s, lrck_edge;

    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk    (clk),
        .rst    (rst),
        .sclk_i (sclk),
        .lrck_i (lrck),
        .sdin_i (sdin),
        .lrck_o (lrck_s),
        .sdin_o (sdin_s),
        .rise_o (rise)
    );

    i2s_state_e             state_q, state_d;
    logic [I2S_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d, shreg_ins, word_c;
    logic                   lrck_q;
    logic                   store, commit, restart, short_c;
    logic [WIDTH-1:0]       m_data_q;
    logic                   m_chan_q, m_valid_q;

    assign lrck_edge = rise && (lrck_s != lrck_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= I2S_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = I2S_ST_IDLE;
        end else if (state_q == I2S_ST_IDLE && lrck_edge) begin
            state_d = I2S_ST_SHIFT;
        end
    end

    always_comb begin
        store   = 1'b0;
        commit  = 1'b0;
        restart = 1'b0;
        if (en && rise) begin
            case (state_q)
                I2S_ST_IDLE: begin
                    restart = lrck_edge;
                end
                I2S_ST_SHIFT: begin
                    store   = !lrck_edge;
                    commit  = lrck_edge;
                    restart = lrck_edge;
                end
                default: begin
                end
            endcase
        end
    end

    // Current bit dropped into its MSB-first slot; nothing changes once WIDTH bits are held.
    always_comb begin
        shreg_ins = shreg_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q < WIDTH_C && cnt_q == I2S_CNT_W'(WIDTH - 1 - i)) begin
                shreg_ins[i] = sdin_s;
            end
        end
    end

    // In I2S the edge bit still belongs to the ending slot; in LJ it opens the next one.
    assign word_c  = LJ ? shreg_q : shreg_ins;
    assign short_c = LJ ? (cnt_q < WIDTH_C) : (cnt_q < WIDTH_M1_C);

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (!en) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (restart) begin
            cnt_d   = '0;
            shreg_d = '0;
            if (LJ) begin
                shreg_d[WIDTH-1] = sdin_s;
                cnt_d            = ONE_C;
            end
        end else if (store) begin
            shreg_d = shreg_ins;
            if (cnt_q != SLOT_MAX_C) begin
                cnt_d = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            lrck_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            if (rise) begin
                lrck_q <= lrck_s;
            end
        end
    end

    // A held word is never overwritten; a commit that finds it stalled is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q  <= '0;
            m_chan_q  <= I2S_CHAN_LEFT;
            m_valid_q <= 1'b0;
        end else if (commit && (!m_valid_q || m_ready)) begin
            m_data_q  <= word_c;
            m_chan_q  <= lrck_q ? I2S_CHAN_RIGHT : I2S_CHAN_LEFT;
            m_valid_q <= 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_data     = m_data_q;
    assign m_chan     = m_chan_q;
    assign m_valid    = m_valid_q;
    assign overrun    = commit && m_valid_q && !m_ready;
    assign short_slot = commit && short_c;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Bench for i2s_rx_stream: an I2S and a left-justified instance share one bit/word
// clock and receive the same slot sequence, compared against a slot-level model.
module tb_i2s_rx_stream;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rst, en, sclk, lrck, sdin0, sdin1, mReady;
    logic [W-1:0] mData0, mData1;
    logic mChan0, mChan1, mValid0, mValid1, ovr0, ovr1, shs0, shs1;

    always #5 clk = ~clk;

    i2s_rx_stream #(.WIDTH(W), .SLOT_MAX(32), .MODE(0), .SYNC_STAGES(2)) dutI2s (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .lrck(lrck), .sdin(sdin0),
        .m_data(mData0), .m_chan(mChan0), .m_valid(mValid0), .m_ready(mReady),
        .overrun(ovr0), .short_slot(shs0)
    );

    i2s_rx_stream #(.WIDTH(W), .SLOT_MAX(32), .MODE(1), .SYNC_STAGES(2)) dutLj (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .lrck(lrck), .sdin(sdin1),
        .m_data(mData1), .m_chan(mChan1), .m_valid(mValid1), .m_ready(mReady),
        .overrun(ovr1), .short_slot(shs1)
    );

    typedef struct {
        bit          lr;
        int          len;
        logic [63:0] word;
        logic [W-1:0] expData;
        bit          expShort;
    } vec_t;

    vec_t vecs[11];

    logic [W:0] expQ[$];
    logic [W:0] got0[$];
    logic [W:0] got1[$];
    int shortCnt0 = 0, shortCnt1 = 0, ovrCnt0 = 0, ovrCnt1 = 0;
    int expShort = 0, expOvr = 0;
    int checks = 0, passes = 0;

    bit prevBit = 1'b0;
    bit mLastLr, mArmed, mFull, mPendChan, mPendShort, heldChan;
    logic [W-1:0] mPendData, heldData;

    // Handshakes and flag pulses are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mValid0 && mReady) got0.push_back({mChan0, mData0});
        if (mValid1 && mReady) got1.push_back({mChan1, mData1});
        if (ovr0) ovrCnt0++;
        if (ovr1) ovrCnt1++;
        if (shs0) shortCnt0++;
        if (shs1) shortCnt1++;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] slotExpect(input int len, input logic [63:0] word);
        logic [63:0] t;
        if (len >= W) t = word >> (len - W);
        else t = word << (W - len);
        return t[W-1:0];
    endfunction

    // Slot-level model: a slot is delivered when the next slot with the other lrck starts.
    task automatic modelStart(input bit lr, input logic [W-1:0] d, input bit sh);
        if (lr != mLastLr) begin
            if (mArmed) begin
                if (mPendShort) expShort++;
                if (!mReady && mFull) begin
                    expOvr++;
                end else begin
                    expQ.push_back({mPendChan, mPendData});
                    if (!mReady) begin
                        mFull    = 1'b1;
                        heldData = mPendData;
                        heldChan = mPendChan;
                    end
                end
            end
            mArmed = 1'b1;
        end
        mLastLr    = lr;
        mPendData  = d;
        mPendChan  = lr;
        mPendShort = sh;
    endtask

    task automatic sendBit(input bit lr, input bit b);
        @(posedge clk); #1;
        sclk  = 1'b0;
        lrck  = lr;
        sdin0 = prevBit;
        sdin1 = b;
        repeat (4) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (4) @(posedge clk);
        prevBit = b;
    endtask

    task automatic sendBits(input bit lr, input int len, input logic [63:0] word,
                            input int from, input int upto);
        for (int i = from; i < upto; i++) sendBit(lr, word[len-1-i]);
    endtask

    task automatic applyStimulus(input bit lr, input int len, input logic [63:0] word,
                                 input logic [W-1:0] d, input bit sh);
        modelStart(lr, d, sh);
        sendBits(lr, len, word, 0, len);
    endtask

    task automatic applyRandomSlot(input bit lr);
        int len;
        logic [63:0] word;
        len  = $urandom_range(8, 32);
        word = {$urandom(), $urandom()} & ((64'd1 << len) - 64'd1);
        applyStimulus(lr, len, word, slotExpect(len, word), len < W);
    endtask

    task automatic checkHeld(input string name);
        @(negedge clk);
        check({name, " valid i2s"}, mValid0, 1'b1);
        check({name, " valid lj"}, mValid1, 1'b1);
        check({name, " held i2s"}, {mChan0, mData0}, {heldChan, heldData});
        check({name, " held lj"}, {mChan1, mData1}, {heldChan, heldData});
    endtask

    task automatic checkOutput(input string phase);
        repeat (4) @(posedge clk);
        check({phase, " count i2s"}, got0.size(), expQ.size());
        check({phase, " count lj"}, got1.size(), expQ.size());
        foreach (expQ[i]) begin
            if (i < got0.size()) check($sformatf("%s word%0d i2s", phase, i), got0[i], expQ[i]);
            if (i < got1.size()) check($sformatf("%s word%0d lj", phase, i), got1[i], expQ[i]);
        end
        check({phase, " short i2s"}, shortCnt0, expShort);
        check({phase, " short lj"}, shortCnt1, expShort);
        check({phase, " overrun i2s"}, ovrCnt0, expOvr);
        check({phase, " overrun lj"}, ovrCnt1, expOvr);
        expQ.delete(); got0.delete(); got1.delete();
        shortCnt0 = 0; shortCnt1 = 0; ovrCnt0 = 0; ovrCnt1 = 0;
        expShort = 0; expOvr = 0;
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, " valid i2s"}, mValid0, 1'b0);
        check({name, " valid lj"}, mValid1, 1'b0);
        check({name, " data i2s"}, {mChan0, mData0}, '0);
        check({name, " data lj"}, {mChan1, mData1}, '0);
        check({name, " flags i2s"}, {ovr0, shs0}, 2'b00);
        check({name, " flags lj"}, {ovr1, shs1}, 2'b00);
    endtask

    initial begin
        logic [63:0] w;

        vecs[0]  = '{1'b0, 32, 64'h0000_0000, 24'h000000, 1'b0};
        vecs[1]  = '{1'b1, 32, 64'h1234_5600, 24'h123456, 1'b0};
        vecs[2]  = '{1'b0, 32, 64'hA5A5_A500, 24'hA5A5A5, 1'b0};
        vecs[3]  = '{1'b1, 32, 64'h5A5A_5A00, 24'h5A5A5A, 1'b0};
        vecs[4]  = '{1'b0, 32, 64'h8000_0100, 24'h800001, 1'b0};
        vecs[5]  = '{1'b1, 32, 64'h7FFF_FFFF, 24'h7FFFFF, 1'b0};
        vecs[6]  = '{1'b0, 16, 64'h0000_1234, 24'h123400, 1'b1};
        vecs[7]  = '{1'b1, 16, 64'h0000_ABCD, 24'hABCD00, 1'b1};
        vecs[8]  = '{1'b0, 24, 64'h00FE_DCBA, 24'hFEDCBA, 1'b0};
        vecs[9]  = '{1'b1, 23, 64'h007F_FFFF, 24'hFFFFFE, 1'b1};
        vecs[10] = '{1'b0, 32, 64'h0000_0000, 24'h000000, 1'b0};

        rst = 1'b1; en = 1'b1; sclk = 1'b0; lrck = 1'b0;
        sdin0 = 1'b0; sdin1 = 1'b0; mReady = 1'b1;
        mLastLr = 1'b0; mArmed = 1'b0; mFull = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i].lr, vecs[i].len, vecs[i].word, vecs[i].expData, vecs[i].expShort);
        checkOutput("table");

        for (int i = 0; i < 31; i++) applyRandomSlot(i % 2 == 0);
        checkOutput("random");

        // Two commits while stalled: the first is held, the second is dropped.
        @(posedge clk); #1 mReady = 1'b0;
        applyRandomSlot(1'b0);
        checkHeld("bp first");
        applyRandomSlot(1'b1);
        checkHeld("bp second");
        @(posedge clk); #1 mReady = 1'b1;
        mFull = 1'b0;
        checkOutput("backpressure");

        w = {32'h0, $urandom()};
        modelStart(1'b0, slotExpect(32, w), 1'b0);
        sendBits(1'b0, 32, w, 0, 10);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checkResetOutputs("mid reset");
        mArmed = 1'b0; mLastLr = 1'b0; mFull = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sendBits(1'b0, 32, w, 10, 32);
        applyRandomSlot(1'b1);
        applyRandomSlot(1'b0);
        checkOutput("reset slot");

        w = {32'h0, $urandom()};
        modelStart(1'b1, slotExpect(32, w), 1'b0);
        sendBits(1'b1, 32, w, 0, 10);
        @(posedge clk); #1 en = 1'b0;
        mArmed = 1'b0;
        sendBits(1'b1, 32, w, 10, 20);
        @(posedge clk); #1 en = 1'b1;
        sendBits(1'b1, 32, w, 20, 32);
        applyRandomSlot(1'b0);
        applyRandomSlot(1'b1);
        applyRandomSlot(1'b0);
        checkOutput("enable");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
